// File: rtl/riscv_str_ops_unit_if.sv
// Request/result bundle for the string-transform execution unit.
// The EX-stage side drives the request and result-accept signals (master);
// the unit drives readiness and the registered result (slave).

interface riscv_str_ops_unit_if #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
);
   localparam int CNT_W = $clog2(WIDTH / 8 + 1);

   logic              enable_i;
   logic [OP_W-1:0]   operator_i;
   logic [WIDTH-1:0]  operand_i;
   logic              ready_o;
   logic              flush_i;
   logic [WIDTH-1:0]  result_o;
   logic [CNT_W-1:0]  changed_cnt_o;
   logic              nul_found_o;
   logic              valid_o;
   logic              result_ready_i;

   modport master (
      output enable_i,
      output operator_i,
      output operand_i,
      output flush_i,
      output result_ready_i,
      input  ready_o,
      input  result_o,
      input  changed_cnt_o,
      input  nul_found_o,
      input  valid_o
   );

   modport slave (
      input  enable_i,
      input  operator_i,
      input  operand_i,
      input  flush_i,
      input  result_ready_i,
      output ready_o,
      output result_o,
      output changed_cnt_o,
      output nul_found_o,
      output valid_o
   );
endinterface

// File: rtl/riscv_str_ops_unit.sv
// Multi-cycle string-transform unit for the EX stage.
// A packed little-endian byte string (byte0 = first char) is rewritten in
// place LANES bytes per cycle (UPPER / LOWER / LEET / ROT13). Everything from
// the first NUL byte onward passes through untouched, and the unit reports how
// many bytes changed and whether a NUL was seen. The result is held until the
// consumer takes it; flush_i drops whatever is in flight.

module riscv_str_ops_unit #(
   parameter int                      WIDTH         = 32,
   parameter int                      LANES         = 1,
   parameter int                      STR_OP_WIDTH  = 3,
   parameter logic [STR_OP_WIDTH-1:0] STR_OP_UPPER  = 3'd0,
   parameter logic [STR_OP_WIDTH-1:0] STR_OP_LOWER  = 3'd1,
   parameter logic [STR_OP_WIDTH-1:0] STR_OP_LEET   = 3'd2,
   parameter logic [STR_OP_WIDTH-1:0] STR_OP_ROT13  = 3'd3
) (
   input logic                 clk,
   input logic                 rst_n,
   riscv_str_ops_unit_if.slave bus
);

   localparam int NBYTES = WIDTH / 8;
   localparam int BEATS  = NBYTES / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = $clog2(NBYTES + 1);

   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   state_nxt_s;

   logic                     accept_s;
   logic                     last_beat_s;
   logic                     step_s;
   logic                     finish_s;
   logic                     ready_s;
   logic                     valid_s;

   logic [STR_OP_WIDTH-1:0]  op_r;
   logic [WIDTH-1:0]         data_r;
   logic [BEAT_W-1:0]        beat_r;
   logic [CNT_W-1:0]         cnt_r;
   logic                     nul_r;

   logic [WIDTH-1:0]         data_nxt_s;
   logic [CNT_W-1:0]         cnt_nxt_s;
   logic                     nul_nxt_s;
   logic [7:0]               lane_in_s;
   logic [7:0]               lane_out_s;

   logic                     ready_r;
   logic                     valid_r;
   logic [WIDTH-1:0]         result_r;
   logic [CNT_W-1:0]         cnt_out_r;
   logic                     nul_out_r;

   // Single-character rewrite; anything that is not a letter, or an unknown
   // operator, comes back unchanged.
   function automatic logic [7:0] xform_byte(input logic [STR_OP_WIDTH-1:0] op,
                                             input logic [7:0]              b);
      logic       is_lo;
      logic       is_up;
      logic [7:0] r;
      is_lo = (b >= 8'h61) && (b <= 8'h7A);
      is_up = (b >= 8'h41) && (b <= 8'h5A);
      r     = b;
      case (op)
         STR_OP_UPPER: begin
            if (is_lo) r = b - 8'h20;
            else       r = b;
         end
         STR_OP_LOWER: begin
            if (is_up) r = b + 8'h20;
            else       r = b;
         end
         STR_OP_LEET: begin
            case (b)
               8'h61, 8'h41: r = 8'h34;
               8'h65, 8'h45: r = 8'h33;
               8'h69, 8'h49: r = 8'h31;
               8'h6F, 8'h4F: r = 8'h30;
               8'h73, 8'h53: r = 8'h35;
               8'h74, 8'h54: r = 8'h37;
               default:      r = b;
            endcase
         end
         STR_OP_ROT13: begin
            if (is_lo)      r = (b < 8'h6E) ? (b + 8'd13) : (b - 8'd13);
            else if (is_up) r = (b < 8'h4E) ? (b + 8'd13) : (b - 8'd13);
            else            r = b;
         end
         default: r = b;
      endcase
      return r;
   endfunction

   assign accept_s    = (state_r == ST_IDLE) && bus.enable_i && ready_r && !bus.flush_i;
   assign last_beat_s = (beat_r == BEAT_LAST);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: flush wins over every other transition.
   always_comb begin
      state_nxt_s = state_r;
      if (bus.flush_i) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) state_nxt_s = ST_BUSY;
               else          state_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
               if (last_beat_s) state_nxt_s = ST_DONE;
               else             state_nxt_s = ST_BUSY;
            end
            ST_DONE: begin
               if (bus.result_ready_i) state_nxt_s = ST_IDLE;
               else                    state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: datapath strobes and next values of the handshake flags.
   always_comb begin
      step_s   = 1'b0;
      finish_s = 1'b0;
      if ((state_r == ST_BUSY) && !bus.flush_i) begin
         step_s   = 1'b1;
         finish_s = last_beat_s;
      end else begin
         step_s   = 1'b0;
         finish_s = 1'b0;
      end
      ready_s = (state_nxt_s == ST_IDLE);
      valid_s = (state_nxt_s == ST_DONE);
   end

   // Rewrite the current beat's lanes; the NUL latch carries across lanes and beats.
   always_comb begin
      data_nxt_s = data_r;
      cnt_nxt_s  = cnt_r;
      nul_nxt_s  = nul_r;
      lane_in_s  = 8'h00;
      lane_out_s = 8'h00;
      for (int l = 0; l < LANES; l++) begin
         lane_in_s = data_r[(int'(beat_r) * LANES + l) * 8 +: 8];
         if (nul_nxt_s || (lane_in_s == 8'h00)) begin
            nul_nxt_s  = 1'b1;
            lane_out_s = lane_in_s;
         end else begin
            lane_out_s = xform_byte(op_r, lane_in_s);
         end
         data_nxt_s[(int'(beat_r) * LANES + l) * 8 +: 8] = lane_out_s;
         if (lane_out_s != lane_in_s) begin
            cnt_nxt_s = cnt_nxt_s + CNT_ONE;
         end else begin
            cnt_nxt_s = cnt_nxt_s;
         end
      end
   end

   // Working registers: capture the request on accept, advance one beat per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= '0;
         data_r <= '0;
         beat_r <= '0;
         cnt_r  <= '0;
         nul_r  <= 1'b0;
      end else if (accept_s) begin
         op_r   <= bus.operator_i;
         data_r <= bus.operand_i;
         beat_r <= '0;
         cnt_r  <= '0;
         nul_r  <= 1'b0;
      end else if (step_s) begin
         data_r <= data_nxt_s;
         beat_r <= beat_r + BEAT_ONE;
         cnt_r  <= cnt_nxt_s;
         nul_r  <= nul_nxt_s;
      end
   end

   // Registered outputs; the result set is loaded together with the final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r   <= 1'b1;
         valid_r   <= 1'b0;
         result_r  <= '0;
         cnt_out_r <= '0;
         nul_out_r <= 1'b0;
      end else begin
         ready_r <= ready_s;
         valid_r <= valid_s;
         if (finish_s) begin
            result_r  <= data_nxt_s;
            cnt_out_r <= cnt_nxt_s;
            nul_out_r <= nul_nxt_s;
         end
      end
   end

   assign bus.ready_o       = ready_r;
   assign bus.valid_o       = valid_r;
   assign bus.result_o      = result_r;
   assign bus.changed_cnt_o = cnt_out_r;
   assign bus.nul_found_o   = nul_out_r;

endmodule

// File: tb/tb_riscv_str_ops_unit.sv
// Bench for riscv_str_ops_unit: one LANES=1 and one LANES=4 instance, selected
// by 'sel'. Expected results are queued at accept and popped when valid_o rises.

module tb_riscv_str_ops_unit;

   localparam logic [2:0] OP_UPPER = 3'd0;
   localparam logic [2:0] OP_LOWER = 3'd1;
   localparam logic [2:0] OP_LEET  = 3'd2;
   localparam logic [2:0] OP_ROT13 = 3'd3;
   localparam logic [2:0] OP_BAD   = 3'd6;

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  cnt;
      logic        nul;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b0;
   logic        flush = 1'b0;
   logic        rrdy  = 1'b0;
   logic [2:0]  op    = 3'd0;
   logic [31:0] opd   = 32'h0;
   int          sel   = 0;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_result;
   logic [2:0]  o_cnt;
   logic        o_nul;

   riscv_str_ops_unit_if #(.WIDTH(32), .OP_W(3)) bus1 ();
   riscv_str_ops_unit_if #(.WIDTH(32), .OP_W(3)) bus4 ();

   assign bus1.enable_i       = en && (sel == 0);
   assign bus1.operator_i     = op;
   assign bus1.operand_i      = opd;
   assign bus1.flush_i        = flush;
   assign bus1.result_ready_i = (sel == 0) ? rrdy : 1'b1;
   assign bus4.enable_i       = en && (sel == 1);
   assign bus4.operator_i     = op;
   assign bus4.operand_i      = opd;
   assign bus4.flush_i        = flush;
   assign bus4.result_ready_i = (sel == 1) ? rrdy : 1'b1;

   assign o_ready  = (sel == 0) ? bus1.ready_o       : bus4.ready_o;
   assign o_valid  = (sel == 0) ? bus1.valid_o       : bus4.valid_o;
   assign o_result = (sel == 0) ? bus1.result_o      : bus4.result_o;
   assign o_cnt    = (sel == 0) ? bus1.changed_cnt_o : bus4.changed_cnt_o;
   assign o_nul    = (sel == 0) ? bus1.nul_found_o   : bus4.nul_found_o;

   riscv_str_ops_unit #(.WIDTH(32), .LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   riscv_str_ops_unit #(.WIDTH(32), .LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic int beats_now();
      return (sel == 0) ? 4 : 1;
   endfunction

   // Reference model written independently of the RTL (mod-26 arithmetic, case folding).
   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x);
      exp_t e;
      bit   stop;
      e.res = x; e.cnt = 3'd0; e.nul = 1'b0; stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] c;
         logic [7:0] r;
         bit         up, lo;
         c  = x[i*8 +: 8];
         r  = c;
         up = (c >= 8'd65) && (c <= 8'd90);
         lo = (c >= 8'd97) && (c <= 8'd122);
         if (c == 8'h00) stop = 1'b1;
         if (!stop) begin
            case (o)
               OP_UPPER: if (lo) r = c - 8'd32;
               OP_LOWER: if (up) r = c + 8'd32;
               OP_LEET: if (up || lo) begin
                  case (c | 8'h20)
                     8'h61: r = 8'h34;
                     8'h65: r = 8'h33;
                     8'h69: r = 8'h31;
                     8'h6F: r = 8'h30;
                     8'h73: r = 8'h35;
                     8'h74: r = 8'h37;
                     default: r = c;
                  endcase
               end
               OP_ROT13: begin
                  if (up) r = 8'(65 + (int'(c) - 65 + 13) % 26);
                  if (lo) r = 8'(97 + (int'(c) - 97 + 13) % 26);
               end
               default: r = c;
            endcase
         end
         if (r != c) e.cnt = e.cnt + 3'd1;
         e.res[i*8 +: 8] = r;
      end
      e.nul = stop;
      return e;
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input exp_t e, input int hold);
      exp_t ex;
      int   lat;
      @(negedge clk);
      n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL ready_idle sel=%0d actual=%b required=1", sel, o_ready); end
      en = 1'b1; op = o; opd = x; rrdy = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      en = 1'b0;
      n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL ready_busy sel=%0d actual=%b required=0", sel, o_ready); end
      lat = 0;
      while (o_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (lat !== beats_now()) begin n_err++; $display("FAIL latency sel=%0d op=%0d in=%h actual=%0d required=%0d", sel, o, x, lat, beats_now()); end
      if (o_valid !== 1'b1) begin
         void'(sb.pop_front());
         rrdy = 1'b1; @(posedge clk); #1; rrdy = 1'b0;
         return;
      end
      ex = sb.pop_front();
      n_cmp++; if (o_result !== ex.res) begin n_err++; $display("FAIL result sel=%0d op=%0d in=%h actual=%h required=%h", sel, o, x, o_result, ex.res); end
      n_cmp++; if (o_cnt !== ex.cnt) begin n_err++; $display("FAIL changed_cnt sel=%0d op=%0d in=%h actual=%0d required=%0d", sel, o, x, o_cnt, ex.cnt); end
      n_cmp++; if (o_nul !== ex.nul) begin n_err++; $display("FAIL nul_found sel=%0d op=%0d in=%h actual=%b required=%b", sel, o, x, o_nul, ex.nul); end
      repeat (hold) begin
         @(posedge clk); #1;
         n_cmp++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== ex.res || o_cnt !== ex.cnt) begin
            n_err++; $display("FAIL hold sel=%0d actual=v%b r%b %h/%0d required=v1 r0 %h/%0d", sel, o_valid, o_ready, o_result, o_cnt, ex.res, ex.cnt);
         end
      end
      rrdy = 1'b1;
      @(posedge clk); #1;
      rrdy = 1'b0;
      n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL release sel=%0d actual=v%b r%b required=v0 r1", sel, o_valid, o_ready); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; flush = 1'b0; rrdy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         sel = s; #1;
         n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready sel=%0d actual=%b required=1", sel, o_ready); end
         n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid sel=%0d actual=%b required=0", sel, o_valid); end
         n_cmp++; if (o_result !== 32'h0 || o_cnt !== 3'd0 || o_nul !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs sel=%0d actual=%h/%0d/%b required=0/0/0", sel, o_result, o_cnt, o_nul);
         end
      end
      sel = 0; #1;
   endtask

   task automatic test_vectors();
      run_op(OP_UPPER, 32'h21636261, {32'h21434241, 3'd3, 1'b0}, 0);
      run_op(OP_ROT13, 32'h6C6C6548, {32'h79797255, 3'd4, 1'b0}, 0);
      run_op(OP_ROT13, 32'h5A7A6E4E, {32'h4D6D6141, 3'd4, 1'b0}, 0);
      run_op(OP_ROT13, 32'h40614D6D, {32'h406E5A7A, 3'd3, 1'b0}, 0);
      run_op(OP_LEET,  32'h74736574, {32'h37353337, 3'd4, 1'b0}, 0);
      run_op(OP_LEET,  32'h4F534941, {32'h30353134, 3'd4, 1'b0}, 0);
      run_op(OP_LOWER, 32'h21434241, {32'h21636261, 3'd3, 1'b0}, 0);
      run_op(OP_LOWER, 32'h40415A5B, {32'h40617A5B, 3'd2, 1'b0}, 0);
      run_op(OP_UPPER, 32'h7B60415A, {32'h7B60415A, 3'd0, 1'b0}, 0);
      run_op(OP_UPPER, 32'h41006261, {32'h41004241, 3'd2, 1'b1}, 0);
      run_op(OP_LOWER, 32'h41006261, {32'h41006261, 3'd0, 1'b1}, 0);
      run_op(OP_UPPER, 32'h00616161, {32'h00414141, 3'd3, 1'b1}, 0);
      run_op(OP_UPPER, 32'h61616100, {32'h61616100, 3'd0, 1'b1}, 0);
      run_op(OP_BAD,   32'h6C6C6548, {32'h6C6C6548, 3'd0, 1'b0}, 0);
   endtask

   task automatic test_backpressure();
      run_op(OP_UPPER, 32'h7A797861, {32'h5A595841, 3'd4, 1'b0}, 10);
   endtask

   task automatic test_flush();
      int vcnt;
      int rdrop;
      @(negedge clk); en = 1'b1; op = OP_UPPER; opd = 32'h64636261; rrdy = 1'b0;
      @(posedge clk); #1; en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1; en = 1'b1; opd = 32'h61616161;
      @(posedge clk); #1;
      flush = 1'b0; en = 1'b0;
      n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL flush_busy actual=v%b r%b required=v0 r1", o_valid, o_ready); end
      vcnt = 0; rdrop = 0;
      repeat (8) begin @(posedge clk); #1; if (o_valid === 1'b1) vcnt++; if (o_ready !== 1'b1) rdrop++; end
      n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL flush_no_valid actual=%0d required=0", vcnt); end
      n_cmp++; if (rdrop !== 0) begin n_err++; $display("FAIL flush_enable_ignored actual=%0d required=0", rdrop); end
      @(negedge clk); en = 1'b1; op = OP_LOWER; opd = 32'h41424344;
      @(posedge clk); #1; en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL done_before_flush actual=%b required=1", o_valid); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL flush_done actual=v%b r%b required=v0 r1", o_valid, o_ready); end
      run_op(OP_UPPER, 32'h61616161, {32'h41414141, 3'd4, 1'b0}, 0);
   endtask

   task automatic test_reset_mid();
      int vcnt;
      @(negedge clk); en = 1'b1; op = OP_UPPER; opd = 32'h64636261;
      @(posedge clk); #1; en = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_flags actual=r%b v%b required=r1 v0", o_ready, o_valid); end
      n_cmp++; if (o_result !== 32'h0 || o_cnt !== 3'd0 || o_nul !== 1'b0) begin
         n_err++; $display("FAIL async_reset_outputs actual=%h/%0d/%b required=0/0/0", o_result, o_cnt, o_nul);
      end
      @(negedge clk); rst_n = 1'b1;
      vcnt = 0;
      repeat (8) begin @(posedge clk); #1; if (o_valid === 1'b1) vcnt++; end
      n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL reset_no_valid actual=%0d required=0", vcnt); end
      run_op(OP_UPPER, 32'h61616161, {32'h41414141, 3'd4, 1'b0}, 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals[4];
      int   cyc, last_acc, nacc, ngot;
      bit   acc;
      exp_t ex;
      vals[0] = 32'h6C6C6548; vals[1] = 32'h21636261; vals[2] = 32'h5A7A6E4E; vals[3] = 32'h41006261;
      rrdy = 1'b1; en = 1'b1; op = OP_ROT13; opd = vals[0];
      cyc = 0; last_acc = -1; nacc = 0; ngot = 0;
      repeat (40) begin
         @(negedge clk); cyc++;
         if (o_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL b2b_unexpected sel=%0d actual=%h required=none", sel, o_result);
            end else begin
               ex = sb.pop_front(); ngot++;
               if (o_result !== ex.res || o_cnt !== ex.cnt) begin
                  n_err++; $display("FAIL b2b_result sel=%0d actual=%h/%0d required=%h/%0d", sel, o_result, o_cnt, ex.res, ex.cnt);
               end
            end
         end
         acc = (o_ready === 1'b1) && (en === 1'b1);
         if (acc) begin
            sb.push_back(model(op, opd));
            if (last_acc >= 0) begin
               n_cmp++; if (cyc - last_acc !== beats_now() + 2) begin
                  n_err++; $display("FAIL b2b_interval sel=%0d actual=%0d required=%0d", sel, cyc - last_acc, beats_now() + 2);
               end
            end
            last_acc = cyc; nacc++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (nacc == 4) en = 1'b0;
            else opd = vals[nacc];
            op = (nacc % 2 == 1) ? OP_UPPER : OP_ROT13;
         end
      end
      rrdy = 1'b0; en = 1'b0;
      n_cmp++; if (ngot !== 4 || sb.size() !== 0) begin n_err++; $display("FAIL b2b_delivered sel=%0d actual=%0d required=4", sel, ngot); end
      sb.delete();
   endtask

   task automatic test_random(input int n);
      logic [2:0]  o;
      logic [31:0] x;
      for (int k = 0; k < n; k++) begin
         o = 3'($urandom_range(0, 7));
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 11) == 0) x[b*8 +: 8] = 8'h00;
            else x[b*8 +: 8] = 8'($urandom_range(32, 126));
         end
         run_op(o, x, model(o, x), k % 3);
      end
   endtask

   initial begin
      test_reset();
      sel = 0; #1;
      test_vectors();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random(16);
      sel = 1; #1;
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_random(16);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
